// File: rtl/spi_rx_multichannel.sv
// Multi-lane SPI receive datapath: oversamples SCLK/CS_n/MISO on clk, frames on CS_n,
// extracts a WIDTH-bit field per lane and hands all lanes out through valid/ready.
module spi_rx_multichannel #(
  parameter int N_CH          = 4,
  parameter int TOTAL_BITS    = 14,
  parameter int WIDTH         = 12,
  parameter int SKIP_BITS     = 2,
  parameter int SAMPLE_RISING = 1,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    spi_sclk,
  input  logic                    spi_cs_n,
  input  logic [N_CH-1:0]         spi_miso,
  output logic [N_CH*WIDTH-1:0]   data_out,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic                    frame_error,
  output logic [7:0]              overrun_count,
  output logic                    busy
);

  localparam int CW = $clog2(TOTAL_BITS + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(TOTAL_BITS - 1);
  localparam logic [CW-1:0] FIRST_CAP = CW'(SKIP_BITS);
  localparam logic [CW-1:0] END_CAP   = CW'(SKIP_BITS + WIDTH);

  if (SKIP_BITS + WIDTH > TOTAL_BITS) begin : g_bad_frame
    $error("spi_rx_multichannel: SKIP_BITS + WIDTH exceeds TOTAL_BITS");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("spi_rx_multichannel: SYNC_STAGES must be at least 2");
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("spi_rx_multichannel: WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [N_CH-1:0]        miso_sync [SYNC_STAGES];
  logic                   sclk_hist;
  logic                   sclk_s;
  logic                   cs_s;
  logic [N_CH-1:0]        miso_s;
  logic                   sample_edge;

  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic [WIDTH-1:0]       shreg [N_CH];
  logic                   commit_pending;
  logic [N_CH*WIDTH-1:0]  lane_bus;

  // MISO runs through the same depth as SCLK so each lane stays aligned with its edge
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) miso_sync[s] <= '0;
      sclk_hist <= 1'b0;
    end else begin
      sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync      <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      miso_sync[0] <= spi_miso;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) miso_sync[s] <= miso_sync[s-1];
      sclk_hist    <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign miso_s = miso_sync[SYNC_STAGES-1];

  assign sample_edge = (SAMPLE_RISING != 0) ? (sclk_s & ~sclk_hist) : (~sclk_s & sclk_hist);

  // Final edge only shifts the last bit and raises commit_pending; the output stage
  // loads on the following clk, so lanes are complete when data_out is written.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state          <= IDLE;
      busy           <= 1'b0;
      bit_cnt        <= '0;
      frame_error    <= 1'b0;
      commit_pending <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) shreg[i] <= '0;
    end else begin
      frame_error    <= 1'b0;
      commit_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_s) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            for (int unsigned i = 0; i < N_CH; i++) shreg[i] <= '0;
          end
        end
        SHIFT: begin
          if (sample_edge) begin
            if (bit_cnt >= FIRST_CAP && bit_cnt < END_CAP) begin
              for (int unsigned i = 0; i < N_CH; i++)
                shreg[i] <= {shreg[i][WIDTH-2:0], miso_s[i]};
            end
            if (bit_cnt == LAST_IDX) begin
              commit_pending <= 1'b1;
              if (cs_s) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= WAIT_CS;
              end
            end else if (cs_s) begin
              frame_error <= 1'b1;
              state       <= IDLE;
              busy        <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (cs_s) begin
            frame_error <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end
        end
        WAIT_CS: begin
          if (cs_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    lane_bus = '0;
    for (int unsigned i = 0; i < N_CH; i++) lane_bus[i*WIDTH +: WIDTH] = shreg[i];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      data_out      <= '0;
      data_valid    <= 1'b0;
      overrun_count <= '0;
    end else if (commit_pending) begin
      if (!data_valid || data_ready) begin
        data_out   <= lane_bus;
        data_valid <= 1'b1;
      end else if (overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_rx_multichannel.sv
// Directed bench for spi_rx_multichannel: default instance plus a falling-edge,
// no-skip, 16-bit-frame instance.
module tb_spi_rx_multichannel;

  localparam int HP = 2;

  logic        clk;
  logic        reset_b;

  logic        sclk1, cs1, rdy1;
  logic [3:0]  miso1;
  logic [47:0] dout1;
  logic        vld1, fe1, busy1;
  logic [7:0]  ovr1;

  logic        sclk2, cs2, rdy2;
  logic [1:0]  miso2;
  logic [27:0] dout2;
  logic        vld2, fe2, busy2;
  logic [7:0]  ovr2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vld1_n   = 0;
  int fe1_n    = 0;
  int vld2_n   = 0;
  int fe2_n    = 0;
  int rise1    = 0;
  logic prev1  = 1'b0;
  int last_cyc = 0;

  spi_rx_multichannel dut1 (
    .clk(clk), .reset_b(reset_b), .spi_sclk(sclk1), .spi_cs_n(cs1), .spi_miso(miso1),
    .data_out(dout1), .data_valid(vld1), .data_ready(rdy1), .frame_error(fe1),
    .overrun_count(ovr1), .busy(busy1)
  );

  spi_rx_multichannel #(
    .N_CH(2), .TOTAL_BITS(16), .WIDTH(14), .SKIP_BITS(0), .SAMPLE_RISING(0), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .reset_b(reset_b), .spi_sclk(sclk2), .spi_cs_n(cs2), .spi_miso(miso2),
    .data_out(dout2), .data_valid(vld2), .data_ready(rdy2), .frame_error(fe2),
    .overrun_count(ovr2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    vld1_n = vld1_n + int'(vld1);
    fe1_n  = fe1_n + int'(fe1);
    vld2_n = vld2_n + int'(vld2);
    fe2_n  = fe2_n + int'(fe2);
    if (vld1 && !prev1) rise1 = cyc;
    prev1 = vld1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives n rising edges MSB-first; leaves SCLK high after the last edge.
  task automatic send1(input logic [13:0] l0, input logic [13:0] lo, input int n);
    int idx;
    cs1 = 1'b0;
    tick(2*HP);
    for (int k = 0; k < n; k++) begin
      idx   = 13 - k;
      miso1 = {lo[idx], lo[idx], lo[idx], l0[idx]};
      tick(HP);
      sclk1    = 1'b1;
      last_cyc = cyc;
      if (k != n - 1) begin
        tick(HP);
        sclk1 = 1'b0;
      end
    end
  endtask

  task automatic end1();
    tick(HP);
    sclk1 = 1'b0;
    tick(HP);
    cs1 = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    tick(3);
    n_checks++; if (dout1 !== 48'h0) begin n_fail++; $display("FAIL reset_dout1: got %h expected 0", dout1); end
    n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL reset_vld1: got %b expected 0", vld1); end
    n_checks++; if (fe1 !== 1'b0) begin n_fail++; $display("FAIL reset_fe1: got %b expected 0", fe1); end
    n_checks++; if (ovr1 !== 8'h0) begin n_fail++; $display("FAIL reset_ovr1: got %0d expected 0", ovr1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    n_checks++; if (dout2 !== 28'h0) begin n_fail++; $display("FAIL reset_dout2: got %h expected 0", dout2); end
    n_checks++; if (vld2 !== 1'b0) begin n_fail++; $display("FAIL reset_vld2: got %b expected 0", vld2); end
    reset_b = 1'b1;
    tick(4);
  endtask

  task automatic test_basic_frame();
    int v0, f0;
    v0 = vld1_n; f0 = fe1_n;
    send1(14'b01_1010_1010_1010, 14'h3FFF, 14);
    tick(6);
    n_checks++; if (rise1 - last_cyc != 4) begin n_fail++; $display("FAIL basic_latency: got %0d clk expected 4", rise1 - last_cyc); end
    n_checks++; if (vld1_n - v0 != 1) begin n_fail++; $display("FAIL basic_valid_width: got %0d clk expected 1", vld1_n - v0); end
    end1();
    n_checks++; if (dout1 !== {12'hFFF, 12'hFFF, 12'hFFF, 12'hAAA}) begin n_fail++; $display("FAIL basic_data: got %h expected fffffffffaaa", dout1); end
    n_checks++; if (fe1_n - f0 != 0) begin n_fail++; $display("FAIL basic_no_error: got %0d pulses expected 0", fe1_n - f0); end
  endtask

  task automatic test_short_frame();
    int v0, f0;
    v0 = vld1_n; f0 = fe1_n;
    send1(14'h2ABC, 14'h1234, 9);
    end1();
    n_checks++; if (fe1_n - f0 != 1) begin n_fail++; $display("FAIL short_error_pulse: got %0d clk expected 1", fe1_n - f0); end
    n_checks++; if (vld1_n - v0 != 0) begin n_fail++; $display("FAIL short_no_valid: got %0d clk expected 0", vld1_n - v0); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL short_busy: got %b expected 0", busy1); end
    v0 = vld1_n; f0 = fe1_n;
    send1({2'b10, 12'h123}, {2'b11, 12'h5A5}, 14);
    end1();
    n_checks++; if (dout1 !== {12'h5A5, 12'h5A5, 12'h5A5, 12'h123}) begin n_fail++; $display("FAIL short_next_data: got %h expected 5a55a55a5123", dout1); end
    n_checks++; if (vld1_n - v0 != 1) begin n_fail++; $display("FAIL short_next_valid: got %0d clk expected 1", vld1_n - v0); end
    n_checks++; if (fe1_n - f0 != 0) begin n_fail++; $display("FAIL short_next_error: got %0d pulses expected 0", fe1_n - f0); end
  endtask

  task automatic test_overrun();
    rdy1 = 1'b0;
    send1({2'b00, 12'h111}, {2'b00, 12'h111}, 14);
    end1();
    send1({2'b00, 12'h222}, {2'b00, 12'h222}, 14);
    end1();
    n_checks++; if (dout1 !== {4{12'h111}}) begin n_fail++; $display("FAIL overrun_keep_data: got %h expected 111111111111", dout1); end
    n_checks++; if (ovr1 !== 8'd1) begin n_fail++; $display("FAIL overrun_count1: got %0d expected 1", ovr1); end
    n_checks++; if (vld1 !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b expected 1", vld1); end
    for (int f = 0; f < 299; f++) begin
      send1({2'b00, 12'h333}, {2'b00, 12'h333}, 14);
      end1();
    end
    n_checks++; if (ovr1 !== 8'd255) begin n_fail++; $display("FAIL overrun_saturate: got %0d expected 255", ovr1); end
    n_checks++; if (dout1 !== {4{12'h111}}) begin n_fail++; $display("FAIL overrun_keep_data2: got %h expected 111111111111", dout1); end
  endtask

  task automatic test_back_to_back();
    reset_b = 1'b0;
    tick(2);
    reset_b = 1'b1;
    tick(4);
    rdy1 = 1'b0;
    send1({2'b00, 12'h111}, {2'b00, 12'h111}, 14);
    end1();
    n_checks++; if (dout1 !== {4{12'h111}} || vld1 !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %h/%b expected 111111111111/1", dout1, vld1); end
    send1({2'b00, 12'h222}, {2'b00, 12'h222}, 14);
    tick(3);
    rdy1 = 1'b1;
    tick(1);
    rdy1 = 1'b0;
    n_checks++; if (dout1 !== {4{12'h222}}) begin n_fail++; $display("FAIL b2b_data: got %h expected 222222222222", dout1); end
    n_checks++; if (vld1 !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", vld1); end
    n_checks++; if (ovr1 !== 8'd0) begin n_fail++; $display("FAIL b2b_overrun: got %0d expected 0", ovr1); end
    end1();
    n_checks++; if (vld1 !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_hold: got %b expected 1", vld1); end
    rdy1 = 1'b1;
    tick(2);
    n_checks++; if (vld1 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", vld1); end
  endtask

  task automatic test_falling_long_frame();
    int v0, f0, idx;
    logic [17:0] l0, l1;
    l0 = {14'h2D3C, 2'b11, 2'b01};
    l1 = {14'h0F0F, 4'b1010};
    v0 = vld2_n; f0 = fe2_n;
    cs2 = 1'b0;
    tick(2*HP);
    for (int k = 0; k < 18; k++) begin
      idx   = 17 - k;
      sclk2 = 1'b1;
      miso2 = {l1[idx], l0[idx]};
      tick(HP);
      sclk2 = 1'b0;
      tick(HP);
    end
    tick(4);
    n_checks++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL fall_wait_busy: got %b expected 1", busy2); end
    cs2 = 1'b1;
    tick(8);
    n_checks++; if (dout2 !== {14'h0F0F, 14'h2D3C}) begin n_fail++; $display("FAIL fall_data: got %h expected 3c3ed3c", dout2); end
    n_checks++; if (vld2_n - v0 != 1) begin n_fail++; $display("FAIL fall_single_valid: got %0d clk expected 1", vld2_n - v0); end
    n_checks++; if (fe2_n - f0 != 0) begin n_fail++; $display("FAIL fall_no_error: got %0d pulses expected 0", fe2_n - f0); end
    n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL fall_idle: got %b expected 0", busy2); end
  endtask

  task automatic test_reset_mid_shift();
    int v0, f0;
    send1(14'h3FFF, 14'h3FFF, 6);
    tick(4);
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy1); end
    reset_b = 1'b0;
    #1;
    n_checks++; if (dout1 !== 48'h0) begin n_fail++; $display("FAIL midrst_dout: got %h expected 0", dout1); end
    n_checks++; if (busy1 !== 1'b0 || vld1 !== 1'b0 || fe1 !== 1'b0 || ovr1 !== 8'h0) begin
      n_fail++; $display("FAIL midrst_flags: got busy=%b vld=%b fe=%b ovr=%0d expected all 0", busy1, vld1, fe1, ovr1);
    end
    sclk1 = 1'b0;
    cs1   = 1'b1;
    tick(3);
    reset_b = 1'b1;
    tick(4);
    v0 = vld1_n; f0 = fe1_n;
    send1({2'b01, 12'h3C5}, {2'b10, 12'h0C3}, 14);
    end1();
    n_checks++; if (dout1 !== {12'h0C3, 12'h0C3, 12'h0C3, 12'h3C5}) begin n_fail++; $display("FAIL midrst_next_data: got %h expected 0c30c30c33c5", dout1); end
    n_checks++; if (fe1_n - f0 != 0) begin n_fail++; $display("FAIL midrst_no_error: got %0d pulses expected 0", fe1_n - f0); end
    n_checks++; if (vld1_n - v0 != 1) begin n_fail++; $display("FAIL midrst_valid: got %0d clk expected 1", vld1_n - v0); end
  endtask

  initial begin
    reset_b = 1'b0;
    sclk1 = 1'b0; cs1 = 1'b1; miso1 = '0; rdy1 = 1'b1;
    sclk2 = 1'b0; cs2 = 1'b1; miso2 = '0; rdy2 = 1'b1;
    test_reset();
    test_basic_frame();
    test_short_frame();
    test_overrun();
    test_back_to_back();
    test_falling_long_frame();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
